booth_pp_gen: RTL
=================

Name: booth_pp_gen

Overview:
- Radix-4 Booth encoder and partial-product generator for the 10x10 unsigned multiplier.
- Sits directly upstream of the Dadda compression tree.
- Accepts operand pairs over a valid/ready handshake and produces six 13-bit partial-product rows plus six negation bits.
- Two-stage registered pipeline with full back-pressure; one operation per cycle sustained.

Parameters:
- W, 10, operand width in bits (A and B); fixed at 10 for the 6x13 row format; even.
- NPP, 6, number of partial-product rows, equal to W/2+1.
- PPW, 13, partial-product row width, equal to W+3.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  block can accept an operand pair this cycle.
- in_a  in  W  multiplicand, unsigned.
- in_b  in  W  multiplier, unsigned.
- out_valid  out  1  ops/neg valid.
- out_ready  in  1  downstream consumes this cycle.
- out_ops  out  NPP x PPW  packed rows; row i = out_ops[i].
- out_neg  out  NPP  per-row negation carry-in bits, weight 2^(2i).

Behaviour:
- Handshake: transfer when valid && ready, both sides. Once out_valid is high, out_ops and out_neg hold stable until accepted.
- Booth digits:
  - Form Bx = {2'b00, in_b, 1'b0}.
  - Digit i (i=0..5) comes from Bx[2i+2:2i], giving d_i in {-2,-1,0,+1,+2}.
  - Digit 5 is never negative.
- Row generation:
  - mag_i = 0, A, or 2A, zero-extended to 12 bits.
  - neg_i = 1 when d_i < 0 and mag_i != 0. A negative zero digit (B bits 111) gives neg_i=0 and an all-zero row body.
  - out_ops[i][11:0] = mag_i XOR {12{neg_i}}.
  - out_ops[i][12] = ~out_ops[i][11] (sign-extension-elimination bit).
  - out_neg[i] = neg_i.
- Correctness invariant: the sum over i of ((signed(out_ops[i][11:0]) + out_neg[i]) << 2i) equals in_a*in_b exactly, as a 20-bit result.
- Pipeline:
  - Stage S1 registers A and the encoded digits (neg, one, two per row).
  - Stage S2 registers the rows.
  - Each stage has a valid flag.
  - Stage k loads when it is empty or its content moves on this cycle.
  - in_ready = !s1_valid || (s2 loads this cycle).
  - S2 loads when !s2_valid || out_ready.
  - out_valid = s2_valid.
- Latency: 2 cycles from accepted input to out_valid with no stall. Throughput: 1 per cycle while out_ready=1.
- Back-pressure: with out_ready=0, at most 2 operations are held; in_ready drops on the cycle after both stages fill. No operation is lost or duplicated.
- Simultaneous accept and emit in the same cycle is legal; both occur.
- Reset:
  - s1_valid, s2_valid, and out_valid go to 0.
  - out_ops and out_neg reset to all-zero.
  - in_ready is 1 from the first cycle after reset.
  - Reset mid-operation discards in-flight data.
  - rst has priority over every handshake.
- Inputs are ignored when in_valid=0. in_a/in_b need not be stable except in the accept cycle.

Optional Feature:
- Macro: BOOTH_PP_CNT_EN.
- Defined:
  - Adds output port op_count (16 bits).
  - Increments on each output handshake (out_valid && out_ready).
  - Saturates at 16'hFFFF.
  - Cleared to 0 by rst.
- Undefined: port and counter absent. All other behaviour is identical.

Test Plan:
- Reset then single op, a=0x3FF, b=0x3FF, out_ready=1:
  - out_valid rises exactly 2 cycles after accept.
  - Row sum equals 0xFF801.
  - out_neg = 6'b000001 (d0=-1, d1..d4=0, d5=+1).
- b=0x000, a=0x155: all d_i=0, out_neg=0, and every row = 13'h1000. Checker sum = 0.
- Back-pressure:
  - out_ready=0, offer 3 ops (1x1, 2x3, 1023x512) back-to-back.
  - in_ready is 0 when the third op is offered; the third op is not accepted until out_ready is released.
  - After out_ready=1, outputs are 1, 6, 523776 in order, with no duplicates.
- Streaming: 1000 random pairs with random out_ready and in_valid.
  - Every accepted pair appears exactly once, in order.
  - Row-sum invariant holds.
  - out_ops is stable while stalled.
- Assert rst for 1 cycle with 2 ops in flight: out_valid=0 next cycle, in_ready=1, and no stale output emerges later.
- With BOOTH_PP_CNT_EN defined: 5 handshakes give op_count=5. Preloading the counter near 0xFFFF and issuing extra handshakes leaves it at 0xFFFF.

Source files
------------

// File: rtl/booth_pp_gen.sv
// -----------------------------------------------------------------------------
// booth_pp_gen
//
// Radix-4 Booth encoder and partial-product generator for the 10x10 unsigned
// multiplier. Feeds the Dadda compression tree directly. Two registered stages
// with full back-pressure and one operation per cycle sustained.
//
//   S1 : registers multiplicand A and the per-row Booth controls (neg/one/two)
//   S2 : registers the finished partial-product rows and negation bits
//
// Ports
//   clk        in   clock, rising edge
//   rst        in   synchronous active-high reset
//   in_valid   in   operand pair valid
//   in_ready   out  operand pair can be accepted this cycle
//   in_a       in   multiplicand, unsigned, W bits
//   in_b       in   multiplier, unsigned, W bits
//   out_valid  out  out_ops/out_neg valid
//   out_ready  in   downstream consumes this cycle
//   out_ops    out  NPP rows of PPW bits; row i = out_ops[i], weight 2^(2i)
//   out_neg    out  per-row negation carry-in, weight 2^(2i)
//   op_count   out  16-bit saturating count of output handshakes
//                   (only present when BOOTH_PP_CNT_EN is defined)
//
// Row format: bits [11:0] are the one's-complemented magnitude (0, A or 2A);
// bit [12] is the inverted row sign, which lets the compressor drop the usual
// sign-extension columns.
//
// Build option: define BOOTH_PP_CNT_EN to add the op_count port and counter.
// -----------------------------------------------------------------------------
module booth_pp_gen #(
    parameter int W   = 10,
    parameter int NPP = W / 2 + 1,
    parameter int PPW = W + 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [W-1:0]             in_a,
    input  logic [W-1:0]             in_b,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [NPP-1:0][PPW-1:0]  out_ops,
    output logic [NPP-1:0]           out_neg
`ifdef BOOTH_PP_CNT_EN
    ,
    output logic [15:0]              op_count
`endif
);

    localparam int MW = W + 2;  // row body width: room for 2A

    // ------------------------------------------------------------------
    // Pipeline control
    // ------------------------------------------------------------------
    logic s1_valid;
    logic s2_valid;
    logic s1_load;
    logic s2_load;

    assign s2_load   = !s2_valid || out_ready;
    assign s1_load   = !s1_valid || s2_load;
    assign in_ready  = s1_load;
    assign out_valid = s2_valid;

    // ------------------------------------------------------------------
    // Booth encoding of the incoming multiplier
    // ------------------------------------------------------------------
    logic [W+2:0]   bx;
    logic [NPP-1:0] enc_neg;
    logic [NPP-1:0] enc_one;
    logic [NPP-1:0] enc_two;
    logic           a_nonzero;

    assign bx        = {2'b00, in_b, 1'b0};
    assign a_nonzero = (in_a != '0);

    // NOTE: every variable written in an always_comb gets a default before any
    // conditional assignment, so no path can leave it unassigned and infer a latch.
    always_comb begin
        enc_neg = '0;
        enc_one = '0;
        enc_two = '0;
        for (int i = 0; i < NPP; i++) begin
            logic [2:0] trip;
            trip       = bx[2*i +: 3];
            enc_one[i] = trip[1] ^ trip[0];
            enc_two[i] = (trip == 3'b100) || (trip == 3'b011);
            // 111 is a negative zero and a zero multiplicand gives a zero
            // magnitude; neither must raise the negation bit.
            enc_neg[i] = trip[2] && !(trip[1] && trip[0]) && a_nonzero;
        end
    end

    // ------------------------------------------------------------------
    // Stage S1
    // ------------------------------------------------------------------
    logic [W-1:0]   s1_a;
    logic [NPP-1:0] s1_neg;
    logic [NPP-1:0] s1_one;
    logic [NPP-1:0] s1_two;

    // NOTE: sequential state is written with non-blocking assignments so every
    // register samples its inputs as they were before the clock edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
        end else if (s1_load) begin
            s1_valid <= in_valid;
        end
    end

    // NOTE: the S1 payload carries no reset; it is only observed when
    // s1_valid is set, and that flag is what reset clears.
    always_ff @(posedge clk) begin
        if (s1_load && in_valid) begin
            s1_a   <= in_a;
            s1_neg <= enc_neg;
            s1_one <= enc_one;
            s1_two <= enc_two;
        end
    end

    // ------------------------------------------------------------------
    // Row generation from the S1 controls
    // ------------------------------------------------------------------
    logic [NPP-1:0][PPW-1:0] rows;

    always_comb begin
        rows = '0;
        for (int i = 0; i < NPP; i++) begin
            logic [MW-1:0] mag;
            logic [MW-1:0] body;
            if (s1_one[i]) begin
                mag = {2'b00, s1_a};
            end else if (s1_two[i]) begin
                mag = {1'b0, s1_a, 1'b0};
            end else begin
                mag = '0;
            end
            body    = mag ^ {MW{s1_neg[i]}};
            rows[i] = {~body[MW-1], body};
        end
    end

    // ------------------------------------------------------------------
    // Stage S2 (output registers)
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid <= 1'b0;
            out_ops  <= '0;
            out_neg  <= '0;
        end else if (s2_load) begin
            s2_valid <= s1_valid;
            // Bubbles leave the last rows in place rather than loading junk.
            if (s1_valid) begin
                out_ops <= rows;
                out_neg <= s1_neg;
            end
        end
    end

`ifdef BOOTH_PP_CNT_EN
    // ------------------------------------------------------------------
    // Saturating output-handshake counter
    // ------------------------------------------------------------------
    logic [15:0] op_count_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            op_count_q <= '0;
        end else if (out_valid && out_ready && (op_count_q != 16'hFFFF)) begin
            op_count_q <= op_count_q + 16'd1;
        end
    end

    assign op_count = op_count_q;
`endif

endmodule
